control_unit: RTL and testbench

Hardwired control sequencer for the Phase-1 datapath. Replaces the hand-written per-state stimulus currently used to drive register, memory and ALU enables with a state machine that fetches an instruction, decodes the IR fields and issues the register-transfer control signals for register ALU instructions. Sits beside `datapath` and drives every enable/select port of it.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/reg_sel_decoder.sv | 14 +
 rtl/control_unit.sv | 143 ++++++++++++++
 tb/tb_control_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the Phase-1 control sequencer: opcodes, IR field
// positions, sequencer states and the opcode-to-instruction-class mapping.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU3, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } instr_class_t;

  function automatic instr_class_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  return CLS_ALU3;
      OP_MUL, OP_DIV:                 return CLS_MULDIV;
      OP_NEG, OP_NOT:                 return CLS_UNARY;
      OP_NOP:                         return CLS_NOP;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register-select decoder: 4-bit register index plus enable to a one-hot
// R0..R15 strobe vector.
module reg_sel_decoder (
  input  logic [3:0]  index,
  input  logic        enable,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (enable) onehot[index] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer driving the Phase-1 datapath enables.
// Build option: define CU_ILLEGAL_TRAP_EN to halt on an undefined opcode.
//
// state  | meaning
// IDLE   | waiting for run, all enables off
// T0     | PC to MAR, increment PC
// T1     | memory read into MDR, held until mem_ready
// T2     | MDR to IR
// T3..T6 | execute steps, selected by instruction class
// HALT   | stopped, left only by clear
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        PCout,
  output logic        incPC,
  output logic        MARin,
  output logic        read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  opcode,
  output logic        instr_done,
  output logic        halted,
  output logic        illegal
);

  state_t       state, state_nxt;
  instr_class_t cls;
  logic [4:0]   op;
  logic [3:0]   ra, rb, rc;
  logic [3:0]   in_sel, out_sel;
  logic         in_en, out_en, done;
  logic         ir_unused;

  assign op        = ir[IR_OP_LSB +: 5];
  assign ra        = ir[IR_RA_LSB +: 4];
  assign rb        = ir[IR_RB_LSB +: 4];
  assign rc        = ir[IR_RC_LSB +: 4];
  assign ir_unused = ^ir[IR_RC_LSB-1:0];
  assign cls       = classify(op);
  assign halted    = (state == S_HALT);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear)                                    illegal <= 1'b0;
    else if (state == S_T3 && cls == CLS_ILLEGAL) illegal <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    in_en = 1'b0;  in_sel  = ra;
    out_en = 1'b0; out_sel = rb;
    PCout = 1'b0; incPC = 1'b0; MARin = 1'b0; read = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; ZLowOut = 1'b0;
    ZHighOut = 1'b0; HIin = 1'b0; LOin = 1'b0;
    opcode = OP_NOP;
    done = 1'b0;
    instr_done = 1'b0;
    unique case (state)
      S_IDLE: if (run) state_nxt = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; incPC = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        read = 1'b1; MDRin = 1'b1;
        if (mem_ready) state_nxt = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        unique case (cls)
          CLS_ALU3, CLS_MULDIV: begin
            out_en = 1'b1; Yin = 1'b1; state_nxt = S_T4;
          end
          CLS_UNARY: begin
            out_en = 1'b1; opcode = op; Zin = 1'b1; state_nxt = S_T4;
          end
          CLS_NOP:  done = 1'b1;
          CLS_HALT: state_nxt = S_HALT;
          default: begin
`ifdef CU_ILLEGAL_TRAP_EN
            state_nxt = S_HALT;
`else
            done = 1'b1;
`endif
          end
        endcase
      end
      S_T4: begin
        if (cls == CLS_ALU3 || cls == CLS_MULDIV) begin
          out_en = 1'b1; out_sel = rc; opcode = op; Zin = 1'b1;
          state_nxt = S_T5;
        end else if (cls == CLS_UNARY) begin
          ZLowOut = 1'b1; in_en = 1'b1; done = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_T5: begin
        ZLowOut = 1'b1;
        if (cls == CLS_ALU3) begin
          in_en = 1'b1; done = 1'b1;
        end else begin
          LOin = 1'b1; state_nxt = S_T6;
        end
      end
      S_T6: begin
        ZHighOut = 1'b1; HIin = 1'b1; done = 1'b1;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
    // run is only honoured at the end of an instruction
    if (done) begin
      instr_done = 1'b1;
      state_nxt  = run ? S_T0 : S_IDLE;
    end
  end

  reg_sel_decoder u_in_dec  (.index(in_sel),  .enable(in_en),  .onehot(reg_in));
  reg_sel_decoder u_out_dec (.index(out_sel), .enable(out_en), .onehot(reg_out));

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected output
// sequences built from the instruction-class rules, plus directed latency cases.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  logic [15:0] reg_in, reg_out;
  logic        PCout, incPC, MARin, read, MDRin, MDRout, IRin, Yin, Zin;
  logic        ZLowOut, ZHighOut, HIin, LOin, instr_done, halted, illegal;
  logic [4:0]  opcode;

  int checks = 0;
  int failures = 0;
  bit exp_ill = 1'b0;

  typedef struct packed {
    logic [15:0] rin, rout;
    logic pc_out, inc_pc, mar_in, rd, mdr_in, mdr_out, ir_in, y_in, z_in;
    logic zlo, zhi, hi_in, lo_in;
    logic [4:0] opc;
    logic done;
  } out_t;

  typedef struct packed {
    out_t o;
    bit   set_ill;
  } step_t;

  step_t exp_q[$];

  control_unit dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .reg_in(reg_in), .reg_out(reg_out), .PCout(PCout), .incPC(incPC),
    .MARin(MARin), .read(read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin),
    .LOin(LOin), .opcode(opcode), .instr_done(instr_done), .halted(halted),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  function automatic out_t sample();
    return '{reg_in, reg_out, PCout, incPC, MARin, read, MDRin, MDRout, IRin,
             Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, opcode, instr_done};
  endfunction

  function automatic step_t blank();
    step_t s = '0;
    s.o.opc = 5'b11010;
    return s;
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] r);
    return 16'(1) << r;
  endfunction

  function automatic bit defined_op(input logic [4:0] op);
    return op inside {[5'd3:5'd11], 5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd27};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra, rb, rc);
    return {op, ra, rb, rc, 15'($urandom)};
  endfunction

  // Expected per-cycle outputs from T0 through the instruction's last state.
  task automatic build(input logic [4:0] op, input logic [3:0] ra, rb, rc, input int stalls);
    step_t s;
    exp_q.delete();
    s = blank(); s.o.pc_out = 1; s.o.mar_in = 1; s.o.inc_pc = 1; exp_q.push_back(s);
    for (int i = 0; i <= stalls; i++) begin
      s = blank(); s.o.rd = 1; s.o.mdr_in = 1; exp_q.push_back(s);
    end
    s = blank(); s.o.mdr_out = 1; s.o.ir_in = 1; exp_q.push_back(s);
    if (op inside {[5'd3:5'd11], 5'd15, 5'd16}) begin
      s = blank(); s.o.rout = oh(rb); s.o.y_in = 1; exp_q.push_back(s);
      s = blank(); s.o.rout = oh(rc); s.o.opc = op; s.o.z_in = 1; exp_q.push_back(s);
      if (op inside {5'd15, 5'd16}) begin
        s = blank(); s.o.zlo = 1; s.o.lo_in = 1; exp_q.push_back(s);
        s = blank(); s.o.zhi = 1; s.o.hi_in = 1; s.o.done = 1; exp_q.push_back(s);
      end else begin
        s = blank(); s.o.zlo = 1; s.o.rin = oh(ra); s.o.done = 1; exp_q.push_back(s);
      end
    end else if (op inside {5'd17, 5'd18}) begin
      s = blank(); s.o.rout = oh(rb); s.o.opc = op; s.o.z_in = 1; exp_q.push_back(s);
      s = blank(); s.o.zlo = 1; s.o.rin = oh(ra); s.o.done = 1; exp_q.push_back(s);
    end else if (op == 5'd26) begin
      s = blank(); s.o.done = 1; exp_q.push_back(s);
    end else if (op == 5'd27) begin
      exp_q.push_back(blank());
    end else begin
      s = blank(); s.set_ill = 1;
`ifndef CU_ILLEGAL_TRAP_EN
      s.o.done = 1;
`endif
      exp_q.push_back(s);
    end
  endtask

  // Runs exp_q from T0 (called #1 after the edge entering T0); run is
  // randomized except in the final state where it selects T0 or IDLE.
  task automatic exec(input bit run_after, input int stalls, input logic [4:0] op);
    for (int k = 0; k < exp_q.size(); k++) begin
      mem_ready = (k >= 1 + stalls);
      run = (k == exp_q.size() - 1) ? run_after : 1'($urandom);
      @(negedge clock);
      checks++;
      if (sample() !== exp_q[k].o) begin
        failures++;
        $display("FAIL step op=%b k=%0d got=%h exp=%h", op, k, sample(), exp_q[k].o);
      end
      checks++;
      if (illegal !== exp_ill || halted !== 1'b0) begin
        failures++;
        $display("FAIL flags op=%b k=%0d illegal=%b halted=%b exp_illegal=%b exp_halted=0",
                 op, k, illegal, halted, exp_ill);
      end
      @(posedge clock); #1;
      if (exp_q[k].set_ill) exp_ill = 1'b1;
    end
  endtask

  task automatic do_clear();
    run = 1'b0; mem_ready = 1'b1;
    @(negedge clock); clear = 1'b1; #2; clear = 1'b0;
    exp_ill = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic start(input logic [31:0] irv);
    ir = irv; run = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
    #12;
    checks++;
    if (sample() !== blank().o || halted !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset got=%h halted=%b illegal=%b exp=%h", sample(), halted, illegal, blank().o);
    end
    @(negedge clock); clear = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic measure_latency(input string name, input logic [31:0] irv, input int stalls,
                                 input int exp_cycles, input int exp_reads);
    int c, reads;
    bit got;
    do_clear();
    start(irv);
    c = 0; reads = 0; got = 0;
    while (!got && c < 40) begin
      run = 1'b0;
      mem_ready = (c >= 1 + stalls);
      @(negedge clock);
      c++;
      if (read) reads++;
      if (instr_done) got = 1;
      @(posedge clock); #1;
    end
    checks++;
    if (c !== exp_cycles) begin
      failures++; $display("FAIL latency_%s got=%0d exp=%0d", name, c, exp_cycles);
    end
    checks++;
    if (reads !== exp_reads) begin
      failures++; $display("FAIL read_cycles_%s got=%0d exp=%0d", name, reads, exp_reads);
    end
  endtask

  task automatic test_directed();
    measure_latency("add", 32'h1A9B8000, 0, 6, 1);
    measure_latency("neg", {5'b10001, 4'd5, 4'd0, 4'd0, 15'd0}, 0, 5, 1);
    measure_latency("mul", {5'b01111, 4'd0, 4'd2, 4'd3, 15'd0}, 3, 10, 4);
    measure_latency("nop", {5'b11010, 27'd0}, 0, 4, 1);
    measure_latency("div_stall1", {5'b10000, 4'd1, 4'd4, 4'd9, 15'd0}, 1, 8, 2);
    do_clear();
    start(32'h1A9B8000);
    build(5'b00011, 4'd5, 4'd3, 4'd7, 0);
    exec(1'b0, 0, 5'b00011);
    start({5'b10001, 4'd5, 4'd0, 4'd0, 15'd0});
    build(5'b10001, 4'd5, 4'd0, 4'd0, 0);
    exec(1'b0, 0, 5'b10001);
    start({5'b01111, 4'd0, 4'd2, 4'd3, 15'd0});
    build(5'b01111, 4'd0, 4'd2, 4'd3, 3);
    exec(1'b0, 3, 5'b01111);
  endtask

  task automatic test_back_to_back();
    bit in_t0 = 1'b0;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int stalls;
    bit run_after;
    do_clear();
    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
`ifdef CU_ILLEGAL_TRAP_EN
      if (!defined_op(op)) op = 5'd3;
`endif
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      stalls = $urandom_range(0, 3);
      run_after = 1'($urandom);
      if (in_t0) ir = mk_ir(op, ra, rb, rc);
      else start(mk_ir(op, ra, rb, rc));
      build(op, ra, rb, rc, stalls);
      exec(run_after, stalls, op);
      in_t0 = run_after;
      if (!run_after) begin
        @(negedge clock);
        checks++;
        if (sample() !== blank().o) begin
          failures++; $display("FAIL idle_after_done got=%h exp=%h", sample(), blank().o);
        end
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_illegal();
    do_clear();
    start({5'b11111, 27'd0});
    build(5'b11111, 4'd0, 4'd0, 4'd0, 0);
    exec(1'b1, 0, 5'b11111);
    @(negedge clock);
    checks++;
    if (illegal !== 1'b1) begin
      failures++; $display("FAIL illegal_sticky got=%b exp=1", illegal);
    end
    checks++;
`ifdef CU_ILLEGAL_TRAP_EN
    if (halted !== 1'b1 || PCout !== 1'b0) begin
      failures++; $display("FAIL illegal_trap halted=%b PCout=%b exp halted=1 PCout=0", halted, PCout);
    end
`else
    if (halted !== 1'b0 || PCout !== 1'b1) begin
      failures++; $display("FAIL illegal_as_nop halted=%b PCout=%b exp halted=0 PCout=1", halted, PCout);
    end
`endif
    @(posedge clock); #1;
  endtask

  task automatic test_halt();
    do_clear();
    start({5'b11011, 27'd0});
    build(5'b11011, 4'd0, 4'd0, 4'd0, 0);
    exec(1'b1, 0, 5'b11011);
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom);
      @(negedge clock);
      checks++;
      if (halted !== 1'b1 || sample() !== blank().o) begin
        failures++; $display("FAIL halt_hold cyc=%0d halted=%b got=%h exp=%h", i, halted, sample(), blank().o);
      end
      @(posedge clock); #1;
    end
    #2; clear = 1'b1; #1;
    checks++;
    if (halted !== 1'b0 || illegal !== 1'b0 || sample() !== blank().o) begin
      failures++; $display("FAIL halt_clear halted=%b illegal=%b got=%h exp=%h", halted, illegal, sample(), blank().o);
    end
    run = 1'b0; #4; clear = 1'b0; exp_ill = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_clear_mid();
    int rin_seen = 0;
    do_clear();
    start(32'h1A9B8000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (reg_in !== 16'h0) rin_seen++;
      @(posedge clock); #1;
    end
    checks++;
    if (reg_out !== 16'h0080 || opcode !== 5'b00011 || Zin !== 1'b1) begin
      failures++; $display("FAIL add_t4 reg_out=%h opcode=%b Zin=%b exp 0080 00011 1", reg_out, opcode, Zin);
    end
    #2; clear = 1'b1; #1;
    checks++;
    if (sample() !== blank().o || halted !== 1'b0 || illegal !== 1'b0) begin
      failures++; $display("FAIL clear_mid got=%h exp=%h", sample(), blank().o);
    end
    run = 1'b0;
    @(negedge clock); clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (reg_in !== 16'h0 || sample() !== blank().o) rin_seen++;
    end
    checks++;
    if (rin_seen !== 0) begin
      failures++; $display("FAIL clear_no_reg_in bad_cycles=%0d exp=0", rin_seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_illegal();
    test_halt();
    test_clear_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
